// File: rtl/quad_decoder.sv
// Quadrature A/B front end: 2-flop synchroniser, optional stability filter
// (define QDEC_FILTER_EN), Gray-code decode into count-enable/direction pulses.
module quad_decoder #(
  parameter int FiltLen = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       err_clr_i,
  output logic       en_o,
  output logic       up_o,
  output logic       err_o,
  output logic [1:0] ab_o
);

  if (FiltLen < 2 || FiltLen > 255) begin : g_bad_filtlen
    $error("quad_decoder: FiltLen must be in 2..255");
  end

`ifdef QDEC_FILTER_EN
  localparam int InitStg = 3;
`else
  localparam int InitStg = 2;
`endif

  logic [1:0]         meta_q, sync_q;
  logic [1:0]         s;
  logic [1:0]         f;
  logic               f_ok;
  logic [InitStg-1:0] vld_pipe_q;
  logic [1:0]         prev_q;
  logic               init_q, init_d;
  logic               en_q, en_d;
  logic               up_q, up_d;
  logic               err_q, err_d;
  logic [1:0]         diff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q     <= 2'b00;
      sync_q     <= 2'b00;
      vld_pipe_q <= '0;
    end else begin
      meta_q     <= {a_i, b_i};
      sync_q     <= meta_q;
      vld_pipe_q <= {vld_pipe_q[InitStg-2:0], 1'b1};
    end
  end

  assign s = sync_q;

`ifdef QDEC_FILTER_EN
  localparam int CW = $clog2(FiltLen + 1);

  logic [1:0]    f_q, f_d;
  logic [1:0]    s_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The first real sample is loaded straight into f so the filter never
  // has to "accept" the reset value of the synchroniser as a change.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    if (vld_pipe_q[1] && !vld_pipe_q[2]) begin
      f_d   = s;
      cnt_d = '0;
    end else if (s == f_q || s != s_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FiltLen - 2)) begin
      f_d   = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_q      <= 2'b00;
      s_prev_q <= 2'b00;
      cnt_q    <= '0;
    end else begin
      f_q      <= f_d;
      s_prev_q <= s;
      cnt_q    <= cnt_d;
    end
  end

  assign f    = f_q;
  assign f_ok = vld_pipe_q[2];
`else
  assign f    = s;
  assign f_ok = vld_pipe_q[1];
`endif

  // Init waits until f carries a real sample, so the reset value of the
  // synchroniser is never decoded against the live input level.
  always_comb begin
    en_d   = 1'b0;
    up_d   = up_q;
    err_d  = err_q;
    init_d = init_q;
    diff   = prev_q ^ f;
    if (err_clr_i) err_d = 1'b0;
    if (!init_q) begin
      if (f_ok) init_d = 1'b1;
    end else if (diff == 2'b11) begin
      err_d = 1'b1;
    end else if (diff != 2'b00) begin
      en_d = 1'b1;
      up_d = prev_q[1] ^ f[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 2'b00;
      init_q <= 1'b0;
      en_q   <= 1'b0;
      up_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= f;
      init_q <= init_d;
      en_q   <= en_d;
      up_q   <= up_d;
      err_q  <= err_d;
    end
  end

  assign en_o  = en_q;
  assign up_o  = up_q;
  assign err_o = err_q;
  assign ab_o  = prev_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed + random bench for quad_decoder against a sample-history model.
module tb_quad_decoder;
  localparam int FL = 4;
`ifdef QDEC_FILTER_EN
  localparam int TI  = 3;
  localparam int LAT = 2 + FL;
`else
  localparam int TI  = 2;
  localparam int LAT = 2;
`endif

  logic clk_i = 1'b0, rst_i = 1'b1, a_i = 1'b0, b_i = 1'b0, err_clr_i = 1'b0;
  logic en_o, up_o, err_o;
  logic [1:0] ab_o;

  quad_decoder #(.FiltLen(FL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .err_clr_i(err_clr_i),
    .en_o(en_o), .up_o(up_o), .err_o(err_o), .ab_o(ab_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int t;
  logic [1:0] hist[$];
  logic [1:0] sv[$];
  logic [1:0] fq_m, fv_prev, ab_m;
  logic en_m, up_m, err_m;
  int pulses;
  logic [2:0] cnt3;
  logic set_win_seen;

  function automatic int pos(logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; hist.delete(); sv.delete();
    fq_m = 2'b00; fv_prev = 2'b00; ab_m = 2'b00;
    en_m = 1'b0; up_m = 1'b0; err_m = 1'b0;
  endtask

  // Entered and left just after a falling edge.
  task automatic do_reset(input logic [1:0] hold);
    rst_i = 1'b1; {a_i, b_i} = hold; err_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_en", {1'b0, en_o}, 2'b00);
    chk("rst_up", {1'b0, up_o}, 2'b00);
    chk("rst_err", {1'b0, err_o}, 2'b00);
    chk("rst_ab", ab_o, 2'b00);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic tick(input logic [1:0] ab, input logic clr);
    logic [1:0] s_t, fv_t, d;
    logic stable;
    {a_i, b_i} = ab; err_clr_i = clr;
    hist.push_back(ab);
    @(posedge clk_i);
    s_t = (t >= 2) ? hist[t-2] : 2'b00;
    sv.push_back(s_t);
`ifdef QDEC_FILTER_EN
    fv_t = fq_m;
    if (t == 2) fq_m = s_t;
    else if (t > 2 && t - FL + 1 >= 2 && s_t != fq_m) begin
      stable = 1'b1;
      for (int i = t - FL + 1; i <= t; i++) if (sv[i] != s_t) stable = 1'b0;
      if (stable) fq_m = s_t;
    end
`else
    stable = 1'b0;
    fv_t = s_t;
`endif
    en_m = 1'b0;
    if (clr) err_m = 1'b0;
    if (t > TI) begin
      d = fv_prev ^ fv_t;
      if (d == 2'b11) err_m = 1'b1;
      else if (d != 2'b00) begin
        en_m = 1'b1;
        up_m = (pos(fv_t) == (pos(fv_prev) + 1) % 4);
      end
    end
    ab_m = fv_t; fv_prev = fv_t; t++;
    #1;
    chk("en", {1'b0, en_o}, {1'b0, en_m});
    chk("up", {1'b0, up_o}, {1'b0, up_m});
    chk("err", {1'b0, err_o}, {1'b0, err_m});
    chk("ab", ab_o, ab_m);
    if (en_o) begin
      pulses++;
      cnt3 = up_o ? cnt3 + 3'd1 : cnt3 - 3'd1;
    end
    if (clr && err_o) set_win_seen = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic hold_for(input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) tick(ab, 1'b0);
  endtask

  initial begin
    logic [1:0] cur;
    int r, n;
    logic [1:0] fwd[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] rev[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    model_reset();

    // Reset released with both phases high: no pulse, no error, ab settles to 11.
    do_reset(2'b11);
    hold_for(2'b11, 10);
    chk("init_ab11", ab_o, 2'b11);

    // Forward then reverse full cycles, 20 clocks per state.
    do_reset(2'b00);
    hold_for(2'b00, 20);
    pulses = 0; cnt3 = 3'd0;
    foreach (fwd[i]) hold_for(fwd[i], 20);
    chk("fwd_pulses", 2'(pulses), 2'(4));
    chk("fwd_pulses_hi", 2'(pulses >> 2), 2'b01);
    chk("cnt_after_fwd", {1'b0, cnt3[2]}, 2'b01);
    chk("cnt_after_fwd_lo", cnt3[1:0], 2'b00);
    foreach (rev[i]) hold_for(rev[i], 20);
    chk("cnt_after_rev", {1'b0, cnt3[2]}, 2'b00);
    chk("cnt_after_rev_lo", cnt3[1:0], 2'b00);

    // Illegal jump, clear, then clear coinciding with another illegal jump.
    hold_for(2'b11, 20);
    chk("jump_err", {1'b0, err_o}, 2'b01);
    tick(2'b11, 1'b1);
    tick(2'b11, 1'b0);
    chk("clr_err", {1'b0, err_o}, 2'b00);
    set_win_seen = 1'b0;
    for (int i = 0; i <= LAT; i++) tick(2'b00, 1'b1);
    chk("set_wins", {1'b0, set_win_seen}, 2'b01);
    tick(2'b00, 1'b0);
    chk("err_sticky", {1'b0, err_o}, 2'b01);
    tick(2'b00, 1'b1);
    hold_for(2'b00, 10);

    // Short glitch on A, then a change held exactly FL clocks.
    hold_for(2'b10, 3);
    hold_for(2'b00, 12);
    hold_for(2'b10, FL);
    hold_for(2'b00, 12);

    // Asynchronous reset while en_o is high.
    n = 0;
    tick(2'b01, 1'b0);
    while (!en_m && n < 20) begin tick(2'b01, 1'b0); n++; end
    chk("en_before_rst", {1'b0, en_o}, 2'b01);
    rst_i = 1'b1;
    #1;
    chk("async_en", {1'b0, en_o}, 2'b00);
    chk("async_ab", ab_o, 2'b00);
    chk("async_err", {1'b0, err_o}, 2'b00);
    do_reset(2'b01);
    hold_for(2'b01, 10);

    // Random walk: mostly legal steps, occasional jumps and clears.
    cur = 2'b01;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 15);
      if (r == 0) cur = cur ^ 2'b11;
      else if (r <= 6) cur = fwd[pos(cur)];
      else if (r <= 12) cur = rev[(3 - pos(cur) + 1) % 4];
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) tick(cur, ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
